// File: rtl/mem_sram_bridge_pkg.sv
// mem_sram_bridge_pkg
//   Shared definitions for the CPU-to-SRAM-like bus bridges:
//   - bridge_state_t : FSM state encoding (IDLE / REQ / WAIT / DRAIN)
//   - SZ_*           : bus_size codes (log2 of bytes per transfer)
//   - DATA_W_*       : legal data-path widths and helpers
package mem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int DATA_W_32 = 32;
  localparam int DATA_W_64 = 64;

  function automatic logic data_w_legal(input int w);
    return (w == DATA_W_32) || (w == DATA_W_64);
  endfunction

  // Size code used for reads and for irregular strobe patterns.
  function automatic logic [1:0] full_size(input int w);
    return (w == DATA_W_64) ? SZ_DWORD : SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_size_enc.sv
// mem_size_enc
//   Purely combinational strobe -> bus_size encoder, shared by the data-side
//   and instruction-side bridges.
//   Ports:
//     i_strb [STRB_W-1:0] : byte enables (all-zero means read)
//     o_size [1:0]        : log2 of bytes transferred
//   One/two/four/eight enabled bytes map to BYTE/HALF/WORD/DWORD; a read or
//   any other count uses the full bus width (strobe goes out unchanged).
module mem_size_enc
  import mem_sram_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W/8-1:0] i_strb,
  output logic [1:0]          o_size
);

  localparam int STRB_W = DATA_W / 8;

  logic [3:0] w_ones;

  always_comb begin
    w_ones = 4'd0;
    for (int i = 0; i < STRB_W; i++) begin
      w_ones = w_ones + {3'd0, i_strb[i]};
    end
  end

  always_comb begin
    o_size = full_size(DATA_W);
    case (w_ones)
      4'd1:    o_size = SZ_BYTE;
      4'd2:    o_size = SZ_HALF;
      4'd4:    o_size = SZ_WORD;
      4'd8:    o_size = SZ_DWORD;
      default: o_size = full_size(DATA_W);
    endcase
  end

endmodule

// File: rtl/mem_sram_bridge.sv
// mem_sram_bridge
//   Converts a single-cycle CPU memory request into an SRAM-like two-phase
//   bus transaction (address handshake bus_addr_ok, then data bus_data_ok).
//   Ports:
//     clk, rst            : clock, synchronous active-low reset
//     cpu_en/wen/addr/wdata/flush : CPU request (wen==0 means read)
//     cpu_rdata           : last completed read data (registered)
//     cpu_stall           : CPU must hold its request/pipeline (combinational)
//     bus_req/wr/size/addr/wstrb/wdata : bus request, all registered
//     bus_addr_ok/data_ok/rdata        : bus responses
//   A flush after the address handshake cannot cancel the bus transfer, so
//   the bridge moves to DRAIN and silently swallows the data beat.
module mem_sram_bridge
  import mem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_flush,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  bridge_state_t r_state;
  bridge_state_t w_state_next;

  logic              r_bus_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0] w_size;
  logic       w_accept;
  logic       w_read_done;

  mem_size_enc #(
    .DATA_W (DATA_W)
  ) u_size_enc (
    .i_strb (cpu_wen),
    .o_size (w_size)
  );

  assign w_accept    = (r_state == ST_IDLE) && cpu_en && !cpu_flush;
  // Data arriving in WAIT completes the access; data_ok wins over a
  // simultaneous flush because the read has genuinely finished.
  assign w_read_done = (r_state == ST_WAIT) && bus_data_ok && !r_wr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (bus_addr_ok && cpu_flush)  w_state_next = ST_DRAIN;
        else if (bus_addr_ok)          w_state_next = ST_WAIT;
        else if (cpu_flush)            w_state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus_data_ok)     w_state_next = ST_IDLE;
        else if (cpu_flush)  w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus_data_ok) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: the CPU is released as soon as a flush is seen in WAIT,
  // but a new request must wait while an orphaned transfer drains.
  always_comb begin
    cpu_stall = 1'b0;
    case (r_state)
      ST_IDLE:  cpu_stall = cpu_en && !cpu_flush;
      ST_REQ:   cpu_stall = 1'b1;
      ST_WAIT:  cpu_stall = !cpu_flush;
      ST_DRAIN: cpu_stall = cpu_en;
      default:  cpu_stall = 1'b0;
    endcase
  end

  // Request registers only load on acceptance in IDLE, which keeps every
  // bus field stable for the whole time bus_req is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bus_req <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_bus_req <= (w_state_next == ST_REQ);
      if (w_accept) begin
        r_wr    <= |cpu_wen;
        r_size  <= w_size;
        r_addr  <= cpu_addr;
        r_wstrb <= cpu_wen;
        r_wdata <= cpu_wdata;
      end
      if (w_read_done) begin
        r_rdata <= bus_rdata;
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wstrb = r_wstrb;
  assign bus_wdata = r_wdata;
  assign cpu_rdata = r_rdata;

endmodule
